pmod_dac_arbiter: RTL and testbench
===================================

PMOD_DAC_ARBITER -- requirements
Module: pmod_dac_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the DAC.
REQ-002 Parameter RESOLUTION, default 16, DAC word width in bits.
REQ-003 Parameter HOLD_CYCLES, default 16, minimum idle gap in slow_clk cycles after each LDAC pulse.
REQ-004 slow_clk  input  1  block clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset: asynchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester write request.
REQ-007 req_data  input  NUM_REQ*RESOLUTION  per-requester DAC code; requester i occupies bits [i*RESOLUTION +: RESOLUTION].
REQ-008 req_ready  output  NUM_REQ  one-hot acceptance strobe.
REQ-009 grant_id  output  clog2(NUM_REQ)  index of the requester being or last served.
REQ-010 busy  output  1  high from acceptance until return to IDLE.
REQ-011 update_done  output  1  one-cycle pulse coincident with the LDAC pulse.
REQ-012 dac_cs_n, dac_ldac_n, dac_sclk, dac_din  output  1 each  PMOD DAC SPI pins.

Function
REQ-013 States SHALL be IDLE, SHIFT, CS_RISE, LDAC and HOLD.
REQ-014 IDLE: if any req_valid is high, assert req_ready combinationally for exactly one requester, chosen round-robin starting from the index after the last granted (index 0 first after reset).
REQ-015 Transfer occurs on a valid&ready edge: capture that requester's data into the shift register, latch grant_id, advance the RR pointer, go to SHIFT.
REQ-016 Requesters hold valid/data until ready; dropping valid before ready is legal and causes no transfer.
REQ-017 req_ready SHALL be 0 in every state other than IDLE.
REQ-018 SHIFT: 2*RESOLUTION cycles, dac_cs_n=0; each bit spans 2 cycles: sclk low (din updated), then sclk high (DAC samples); MSB first.
REQ-019 dac_sclk SHALL be a registered bit-counter LSB, never a gated clock.
REQ-020 dac_din = shift-register MSB while dac_cs_n=0, otherwise 1.
REQ-021 CS_RISE: 1 cycle, dac_cs_n=1, sclk=0.
REQ-022 LDAC: 1 cycle, dac_ldac_n=0, update_done=1.
REQ-023 HOLD: HOLD_CYCLES cycles with no acceptance; HOLD_CYCLES=0 goes directly to IDLE.
REQ-024 Acceptance-to-update_done latency SHALL be 2*RESOLUTION+1 cycles; acceptance-to-acceptance minimum is 2*RESOLUTION+2+HOLD_CYCLES+1 cycles.
REQ-025 All valids high continuously: grants SHALL rotate 0,1,2,3,0,...
REQ-026 A single requester SHALL be re-granted after HOLD with no starvation penalty.
REQ-027 The bit counter wraps at 2*RESOLUTION-1; the RR pointer wraps NUM_REQ-1 to 0.
REQ-028 Valid changes during SHIFT/CS_RISE/LDAC/HOLD SHALL NOT affect the transfer in flight.

Reset
REQ-029 On rst, immediately: state IDLE, dac_cs_n=1, dac_ldac_n=1, dac_sclk=0, dac_din=1, req_ready=0, busy=0, update_done=0, grant_id=0, RR pointer=0, shift register=0.
REQ-030 rst mid-SHIFT SHALL abort the frame without an LDAC pulse; the DAC register keeps its previous value.
REQ-031 The first acceptance SHALL occur no earlier than the first rising edge after rst deasserts.

Structure
REQ-032 Shared package pmod_dac_pkg SHALL hold the state encoding constants, RESOLUTION default and SPI timing constants.
REQ-033 Sub-module pmod_dac_spi_shifter (load, start, sclk/din/cs_n generation, done) SHALL contain the serializer; the arbiter holds RR logic and the FSM.

Verification
REQ-034 Single request, req0 data 0xA5C3 -> din MSB-first 1010010111000011 sampled on sclk rising edges; LDAC low 33 cycles after acceptance.
REQ-035 All four valid from reset with data 0x1000/0x2000/0x3000/0x4000 -> grant_id sequence 0,1,2,3,0; each frame separated by ≥HOLD_CYCLES.
REQ-036 req2 valid only, held high -> consecutive grants to 2; accept spacing exactly 51 cycles (defaults).
REQ-037 rst pulsed at bit 7 of a 0xFFFF frame -> cs_n=1, din=1, sclk=0 same cycle; no ldac_n low; next accepted frame is complete.
REQ-038 req1 valid dropped during HOLD before acceptance -> no req_ready[1], no frame, busy falls after HOLD.
REQ-039 Data 0x0000 and 0xFFFF -> 16 constant din bits; cs_n low exactly 32 cycles.

Source files
------------

// File: rtl/pmod_dac_pkg.sv
// Shared constants for the PMOD DAC arbiter: FSM encoding, default sizing and SPI timing.
// Also provides the pin bundle type and the round-robin wrap helper.
package pmod_dac_pkg;

    localparam int DEFAULT_NUM_REQ     = 4;
    localparam int DEFAULT_RESOLUTION  = 16;
    localparam int DEFAULT_HOLD_CYCLES = 16;

    // One DAC bit spans a low half (din changes) and a high half (DAC samples).
    localparam int   SCLK_CYCLES_PER_BIT = 2;
    localparam logic IDLE_CS_N           = 1'b1;
    localparam logic IDLE_DIN            = 1'b1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SHIFT   = 3'd1;
    localparam logic [2:0] ST_CS_RISE = 3'd2;
    localparam logic [2:0] ST_LDAC    = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    typedef struct packed {
        logic cs_n;
        logic sclk;
        logic din;
    } spi_pins_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pmod_dac_spi_shifter.sv
// MSB-first serializer for one DAC frame; sclk is the LSB of a registered bit counter.
// o_done is high during the last cycle of the frame so the caller can advance on the same edge.
module pmod_dac_spi_shifter
    import pmod_dac_pkg::*;
#(
    parameter int RESOLUTION = DEFAULT_RESOLUTION
) (
    input  logic                  slow_clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [RESOLUTION-1:0] i_data,
    input  logic                  i_start,
    output spi_pins_t             o_pins,
    output logic                  o_done
);

    localparam int              FRAME_CYCLES = SCLK_CYCLES_PER_BIT * RESOLUTION;
    localparam int              CW           = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0]   LAST_CNT     = CW'(FRAME_CYCLES - 1);

    logic [RESOLUTION-1:0] r_shift;
    logic [CW-1:0]         r_bit_cnt;
    logic                  r_active;
    logic                  w_last;

    assign w_last = r_active && (r_bit_cnt == LAST_CNT);

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_active  <= 1'b0;
        end else begin
            // Advance to the next bit at the end of each sclk-high half.
            if (i_load)
                r_shift <= i_data;
            else if (r_active && r_bit_cnt[0])
                r_shift <= {r_shift[RESOLUTION-2:0], 1'b0};

            if (i_start) begin
                r_active  <= 1'b1;
                r_bit_cnt <= '0;
            end else if (r_active) begin
                if (w_last) begin
                    r_active  <= 1'b0;
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    assign o_pins.cs_n = r_active ? 1'b0 : IDLE_CS_N;
    assign o_pins.sclk = r_bit_cnt[0];
    assign o_pins.din  = r_active ? r_shift[RESOLUTION-1] : IDLE_DIN;
    assign o_done      = w_last;

endmodule

// File: rtl/pmod_dac_arbiter.sv
// Round-robin arbiter sharing one PMOD DAC among NUM_REQ requesters.
// Frame sequence: SHIFT -> CS_RISE -> LDAC pulse -> HOLD gap -> IDLE.
module pmod_dac_arbiter
    import pmod_dac_pkg::*;
#(
    parameter int  NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int  RESOLUTION  = DEFAULT_RESOLUTION,
    parameter int  HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          slow_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*RESOLUTION-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          update_done,
    output logic                          dac_cs_n,
    output logic                          dac_ldac_n,
    output logic                          dac_sclk,
    output logic                          dac_din
);

    localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    logic [2:0]            r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_grant_id;
    logic [HW-1:0]         r_hold_cnt;

    logic [ID_W-1:0]       w_cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]    w_cand_valid;
    logic [ID_W-1:0]       w_sel_idx;
    logic                  w_sel_found;
    logic                  w_accept;
    logic [RESOLUTION-1:0] w_sel_data;
    logic                  w_shift_done;
    spi_pins_t             w_pins;

    // Candidate gi is the requester gi positions after the round-robin pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [31:0] w_sum;
        assign w_sum            = 32'(r_rr_ptr) + 32'(gi);
        assign w_cand_idx[gi]   = ID_W'(w_sum % NUM_REQ);
        assign w_cand_valid[gi] = req_valid[w_cand_idx[gi]];
    end

    always_comb begin
        w_sel_idx   = '0;
        w_sel_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_cand_valid[k]) begin
                w_sel_idx   = w_cand_idx[k];
                w_sel_found = 1'b1;
            end
        end
    end

    // Ready is suppressed while rst is held so nothing is offered during reset.
    assign w_accept   = (r_state == ST_IDLE) && w_sel_found && !rst;
    assign w_sel_data = req_data[int'(w_sel_idx)*RESOLUTION +: RESOLUTION];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = w_accept && (w_sel_idx == ID_W'(gi));
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_SHIFT;
                        r_grant_id <= w_sel_idx;
                        r_rr_ptr   <= ID_W'(rr_next(int'(w_sel_idx), NUM_REQ));
                    end
                end
                ST_SHIFT: begin
                    if (w_shift_done)
                        r_state <= ST_CS_RISE;
                end
                ST_CS_RISE: begin
                    r_state <= ST_LDAC;
                end
                ST_LDAC: begin
                    r_hold_cnt <= '0;
                    r_state    <= (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
                end
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST)
                        r_state <= ST_IDLE;
                    else
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    pmod_dac_spi_shifter #(
        .RESOLUTION (RESOLUTION)
    ) u_shifter (
        .slow_clk (slow_clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_data   (w_sel_data),
        .i_start  (w_accept),
        .o_pins   (w_pins),
        .o_done   (w_shift_done)
    );

    assign grant_id    = r_grant_id;
    assign busy        = (r_state != ST_IDLE);
    assign update_done = (r_state == ST_LDAC);
    assign dac_ldac_n  = (r_state != ST_LDAC);
    assign dac_cs_n    = w_pins.cs_n;
    assign dac_sclk    = w_pins.sclk;
    assign dac_din     = w_pins.din;

endmodule

// File: tb/tb_pmod_dac_arbiter.sv
// Bench for pmod_dac_arbiter: randomized frames checked against a transaction-level model
// of round-robin choice, serial bit order and frame timing.
module tb_pmod_dac_arbiter;

    localparam int NREQ    = 4;
    localparam int RES     = 16;
    localparam int HOLD    = 16;
    localparam int LDAC_AT = 2 * RES + 1;
    localparam int SPACING = 2 * RES + 2 + HOLD + 1;

    logic                 slow_clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*RES-1:0]  req_data;
    logic [NREQ-1:0]      req_ready;
    logic [1:0]           grant_id;
    logic                 busy, update_done, dac_cs_n, dac_ldac_n, dac_sclk, dac_din;

    int vectors     = 0;
    int miscompares = 0;
    int exp_ptr     = 0;

    typedef struct packed {
        int              n_wait;
        logic [3:0]      rdy;
        logic [3:0]      acc_valid;
        logic [63:0]     acc_data;
        int              gid;
        logic [15:0]     bits;
        int              nbits;
        int              cs_low;
        int              ldac_at;
        int              done_at;
        int              ready_in_frame;
        int              busy_hold;
        int              ready_hold;
    } frame_obs_t;

    always #5 slow_clk = ~slow_clk;

    pmod_dac_arbiter #(
        .NUM_REQ     (NREQ),
        .RESOLUTION  (RES),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .slow_clk    (slow_clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .update_done (update_done),
        .dac_cs_n    (dac_cs_n),
        .dac_ldac_n  (dac_ldac_n),
        .dac_sclk    (dac_sclk),
        .dac_din     (dac_din)
    );

    // Reference round-robin: first valid requester at or after the pointer, circularly.
    function automatic int rr_pick(input logic [3:0] v, input int ptr);
        for (int off = 0; off < NREQ; off++)
            if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        return -1;
    endfunction

    // Waits for acceptance, then records one frame and its hold gap (k = cycles after accept).
    // mode 0: keep inputs, 1: drop valid after accept, 2: scramble inputs every cycle.
    task automatic do_frame(input int mode, input int drop_k, output frame_obs_t o);
        logic got;
        logic prev_sclk;
        o = '0;
        o.ldac_at = -1;
        o.done_at = -1;
        got = 1'b0;
        while (!got && o.n_wait < 200) begin
            #1;
            if ((req_ready & req_valid) != 0) begin
                got = 1'b1;
                o.rdy = req_ready;
                o.acc_valid = req_valid;
                o.acc_data = req_data;
            end else begin
                @(negedge slow_clk);
                o.n_wait++;
            end
        end
        if (!got) begin
            o.n_wait = -1;
        end else begin
            prev_sclk = 1'b0;
            for (int k = 0; k < 34; k++) begin
                @(negedge slow_clk);
                if (k == 0) o.gid = int'(grant_id);
                if (!dac_cs_n) o.cs_low++;
                if (!dac_cs_n && dac_sclk && !prev_sclk) begin
                    o.bits = {o.bits[14:0], dac_din};
                    o.nbits++;
                end
                prev_sclk = dac_sclk;
                if (!dac_ldac_n && o.ldac_at < 0) o.ldac_at = k;
                if (update_done && o.done_at < 0) o.done_at = k;
                if (req_ready != 0) o.ready_in_frame++;
                if (mode == 1 && k == 0) req_valid = '0;
                if (mode == 2) begin
                    req_valid = 4'($urandom);
                    req_data  = {$urandom, $urandom};
                end
            end
            for (int k = 34; k < 34 + HOLD; k++) begin
                @(negedge slow_clk);
                if (busy) o.busy_hold++;
                if (req_ready != 0 || !dac_ldac_n || !dac_cs_n) o.ready_hold++;
                if (k == drop_k) req_valid = '0;
            end
        end
    endtask

    task automatic drain();
        req_valid = '0;
        repeat (4) @(negedge slow_clk);
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        rst = 1'b1;
        req_valid = 4'hF;
        req_data = '0;
        @(negedge slow_clk);
        obs = {dac_cs_n, dac_ldac_n, dac_sclk, dac_din, busy, update_done, req_ready, grant_id};
        vectors++;
        if (obs !== 12'b110100_0000_00) begin
            $display("FAIL reset_outputs got %b want 110100000000", obs);
            miscompares++;
        end
        @(negedge slow_clk);
        vectors++;
        if (req_ready !== 4'b0 || busy !== 1'b0) begin
            $display("FAIL reset_no_accept ready=%b busy=%b want 0000/0", req_ready, busy);
            miscompares++;
        end
        req_valid = '0;
        rst = 1'b0;
        exp_ptr = 0;
        @(negedge slow_clk);
    endtask

    task automatic test_single_a5c3();
        frame_obs_t o;
        int exp_id;
        req_data = '0;
        req_data[15:0] = 16'hA5C3;
        req_valid = 4'b0001;
        do_frame(1, -1, o);
        vectors++;
        if (o.n_wait < 0) begin
            $display("FAIL single_timeout got no acceptance within 200 cycles");
            miscompares++;
        end else begin
            exp_id = rr_pick(o.acc_valid, exp_ptr);
            exp_ptr = (exp_id + 1) % NREQ;
            vectors++;
            if (o.rdy !== 4'b0001 || o.gid != exp_id) begin
                $display("FAIL single_grant got rdy=%b id=%0d want 0001/%0d", o.rdy, o.gid, exp_id);
                miscompares++;
            end
            vectors++;
            if (o.bits !== 16'hA5C3 || o.nbits != RES) begin
                $display("FAIL single_din got %h (%0d bits) want a5c3 (16 bits)", o.bits, o.nbits);
                miscompares++;
            end
            vectors++;
            if (o.ldac_at != LDAC_AT || o.done_at != LDAC_AT || o.cs_low != 2 * RES) begin
                $display("FAIL single_timing got ldac=%0d done=%0d cs_low=%0d want %0d/%0d/%0d",
                         o.ldac_at, o.done_at, o.cs_low, LDAC_AT, LDAC_AT, 2 * RES);
                miscompares++;
            end
            vectors++;
            if (o.busy_hold != HOLD || o.ready_hold != 0 || o.ready_in_frame != 0) begin
                $display("FAIL single_hold got busy=%0d bad=%0d rdy_frame=%0d want %0d/0/0",
                         o.busy_hold, o.ready_hold, o.ready_in_frame, HOLD);
                miscompares++;
            end
            @(negedge slow_clk);
            vectors++;
            if (busy !== 1'b0) begin
                $display("FAIL single_busy_end got %b want 0", busy);
                miscompares++;
            end
        end
        drain();
    endtask

    task automatic test_round_robin();
        frame_obs_t o;
        int exp_id;
        rst = 1'b1;
        @(negedge slow_clk);
        rst = 1'b0;
        exp_ptr = 0;
        req_data = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        req_valid = 4'hF;
        for (int f = 0; f < 5; f++) begin
            do_frame(0, -1, o);
            vectors++;
            if (o.n_wait < 0) begin
                $display("FAIL rr_timeout frame %0d got no acceptance", f);
                miscompares++;
            end else begin
                exp_id = rr_pick(o.acc_valid, exp_ptr);
                exp_ptr = (exp_id + 1) % NREQ;
                vectors++;
                if (o.gid != exp_id || o.gid != f % NREQ || o.rdy !== 4'(1 << exp_id)) begin
                    $display("FAIL rr_grant frame %0d got id=%0d rdy=%b want %0d", f, o.gid, o.rdy, exp_id);
                    miscompares++;
                end
                vectors++;
                if (o.bits !== o.acc_data[exp_id*16 +: 16] || o.ldac_at != LDAC_AT) begin
                    $display("FAIL rr_frame %0d got %h ldac=%0d want %h ldac=%0d",
                             f, o.bits, o.ldac_at, o.acc_data[exp_id*16 +: 16], LDAC_AT);
                    miscompares++;
                end
                if (f > 0) begin
                    vectors++;
                    if (50 + o.n_wait != SPACING) begin
                        $display("FAIL rr_spacing frame %0d got %0d want %0d", f, 50 + o.n_wait, SPACING);
                        miscompares++;
                    end
                end
            end
        end
        drain();
    endtask

    task automatic test_back_to_back_single();
        frame_obs_t o;
        req_data = {$urandom, $urandom};
        req_valid = 4'b0100;
        for (int f = 0; f < 3; f++) begin
            do_frame(0, -1, o);
            vectors++;
            if (o.n_wait < 0) begin
                $display("FAIL repeat_timeout frame %0d got no acceptance", f);
                miscompares++;
            end else begin
                exp_ptr = 3;
                vectors++;
                if (o.gid != 2 || o.rdy !== 4'b0100 || o.bits !== req_data[47:32]) begin
                    $display("FAIL repeat_grant frame %0d got id=%0d rdy=%b bits=%h want 2/0100/%h",
                             f, o.gid, o.rdy, o.bits, req_data[47:32]);
                    miscompares++;
                end
                if (f > 0) begin
                    vectors++;
                    if (50 + o.n_wait != SPACING) begin
                        $display("FAIL repeat_spacing frame %0d got %0d want %0d", f, 50 + o.n_wait, SPACING);
                        miscompares++;
                    end
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_midframe();
        frame_obs_t o;
        logic [6:0] obs;
        int ldac_seen;
        logic [15:0] new_data;
        rst = 1'b1;
        @(negedge slow_clk);
        rst = 1'b0;
        exp_ptr = 0;
        req_data = '0;
        req_data[15:0] = 16'hFFFF;
        req_valid = 4'b0001;
        ldac_seen = 0;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL midrst_ready got %b want 0001", req_ready);
            miscompares++;
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge slow_clk);
            if (!dac_ldac_n) ldac_seen++;
        end
        vectors++;
        if (dac_cs_n !== 1'b0 || dac_sclk !== 1'b1) begin
            $display("FAIL midrst_inframe got cs_n=%b sclk=%b want 0/1", dac_cs_n, dac_sclk);
            miscompares++;
        end
        rst = 1'b1;
        #1;
        obs = {dac_cs_n, dac_din, dac_sclk, dac_ldac_n, busy, update_done, |req_ready};
        vectors++;
        if (obs !== 7'b1101000) begin
            $display("FAIL midrst_async got %b want 1101000", obs);
            miscompares++;
        end
        repeat (3) begin
            @(negedge slow_clk);
            if (!dac_ldac_n) ldac_seen++;
        end
        vectors++;
        if (ldac_seen != 0) begin
            $display("FAIL midrst_no_ldac got %0d low cycles want 0", ldac_seen);
            miscompares++;
        end
        new_data = 16'($urandom);
        req_data[15:0] = new_data;
        rst = 1'b0;
        exp_ptr = 0;
        do_frame(1, -1, o);
        vectors++;
        if (o.n_wait != 0 || o.gid != 0 || o.bits !== new_data || o.nbits != RES || o.ldac_at != LDAC_AT) begin
            $display("FAIL midrst_next got wait=%0d id=%0d bits=%h ldac=%0d want 0/0/%h/%0d",
                     o.n_wait, o.gid, o.bits, o.ldac_at, new_data, LDAC_AT);
            miscompares++;
        end
        exp_ptr = 1;
        drain();
    endtask

    task automatic test_drop_in_hold();
        frame_obs_t o;
        int bad;
        req_data = {$urandom, $urandom};
        req_valid = 4'b0010;
        do_frame(0, 40, o);
        vectors++;
        if (o.n_wait < 0 || o.gid != 1 || o.ready_hold != 0 || o.busy_hold != HOLD) begin
            $display("FAIL drop_frame got wait=%0d id=%0d bad=%0d busy=%0d want id 1, 0 bad, busy %0d",
                     o.n_wait, o.gid, o.ready_hold, o.busy_hold, HOLD);
            miscompares++;
        end
        exp_ptr = 2;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge slow_clk);
            if (req_ready != 0 || busy || !dac_cs_n) bad++;
        end
        vectors++;
        if (bad != 0) begin
            $display("FAIL drop_no_frame got %0d active cycles want 0", bad);
            miscompares++;
        end
        drain();
    endtask

    task automatic test_const_data();
        frame_obs_t o;
        logic [15:0] pat;
        int slot;
        for (int t = 0; t < 2; t++) begin
            pat = (t == 0) ? 16'h0000 : 16'hFFFF;
            slot = (t == 0) ? 3 : 0;
            req_data = {$urandom, $urandom};
            req_data[slot*16 +: 16] = pat;
            req_valid = '0;
            req_valid[slot] = 1'b1;
            do_frame(1, -1, o);
            vectors++;
            if (o.n_wait < 0 || o.gid != slot || o.bits !== pat || o.nbits != RES || o.cs_low != 2 * RES) begin
                $display("FAIL const_%h got id=%0d bits=%h n=%0d cs_low=%0d want %0d/%h/16/32",
                         pat, o.gid, o.bits, o.nbits, o.cs_low, slot, pat);
                miscompares++;
            end
            exp_ptr = (slot + 1) % NREQ;
            drain();
        end
    endtask

    task automatic test_random();
        frame_obs_t o;
        int exp_id;
        req_valid = 4'($urandom_range(1, 15));
        req_data = {$urandom, $urandom};
        for (int f = 0; f < 24; f++) begin
            do_frame(2, -1, o);
            vectors++;
            if (o.n_wait < 0) begin
                $display("FAIL rand_timeout frame %0d got no acceptance", f);
                miscompares++;
            end else begin
                exp_id = rr_pick(o.acc_valid, exp_ptr);
                exp_ptr = (exp_id + 1) % NREQ;
                vectors++;
                if (o.gid != exp_id || o.rdy !== 4'(1 << exp_id) ||
                    o.bits !== o.acc_data[exp_id*16 +: 16] || o.ldac_at != LDAC_AT ||
                    o.cs_low != 2 * RES || o.ready_in_frame != 0 || o.busy_hold != HOLD) begin
                    $display("FAIL rand_frame %0d v=%b got id=%0d rdy=%b bits=%h ldac=%0d want id=%0d bits=%h ldac=%0d",
                             f, o.acc_valid, o.gid, o.rdy, o.bits, o.ldac_at,
                             exp_id, o.acc_data[exp_id*16 +: 16], LDAC_AT);
                    miscompares++;
                end
                if (f > 0) begin
                    vectors++;
                    if (50 + o.n_wait != SPACING) begin
                        $display("FAIL rand_spacing frame %0d got %0d want %0d", f, 50 + o.n_wait, SPACING);
                        miscompares++;
                    end
                end
            end
            req_valid = 4'($urandom_range(1, 15));
            req_data = {$urandom, $urandom};
        end
        drain();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        test_reset();
        test_single_a5c3();
        test_round_robin();
        test_back_to_back_single();
        test_reset_midframe();
        test_drop_in_hold();
        test_const_data();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
